// File: rtl/drum_host_driver.sv
// Bus initiator for the DRUM register file: writes an operand pair, waits out the
// compute interval, reads the 16-bit result back and returns it on a response channel.
module drum_host_driver #(
    parameter int ADDR_BITS   = 5,
    parameter int A_ADDR      = 0,
    parameter int B_ADDR      = 1,
    parameter int RLO_ADDR    = 2,
    parameter int RHI_ADDR    = 3,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic signed [7:0]    req_a,
    input  logic signed [7:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_r,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic                 bus_wr_en,
    output logic [7:0]           bus_wdata,
    input  logic [7:0]           bus_rdata,
    output logic                 busy,
    output logic [7:0]           txn_count
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [ADDR_BITS-1:0] A_AD   = ADDR_BITS'(A_ADDR);
    localparam logic [ADDR_BITS-1:0] B_AD   = ADDR_BITS'(B_ADDR);
    localparam logic [ADDR_BITS-1:0] RLO_AD = ADDR_BITS'(RLO_ADDR);
    localparam logic [ADDR_BITS-1:0] RHI_AD = ADDR_BITS'(RHI_ADDR);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_A, ST_WR_B, ST_WAIT, ST_RD_LO, ST_RD_HI, ST_CAP_HI, ST_RESP
    } state_t;

    state_t                  state;
    logic signed [7:0]       b_q;
    logic        [CNT_W-1:0] wait_cnt;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Bus outputs are computed for the state being entered, so each defaults to idle
    // and only the transitions into a bus-active state override them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bus_addr  <= '0;
            bus_wr_en <= 1'b0;
            bus_wdata <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_r     <= 16'd0;
            txn_count <= 8'd0;
            wait_cnt  <= '0;
        end else begin
            bus_addr  <= '0;
            bus_wr_en <= 1'b0;
            bus_wdata <= 8'd0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        b_q       <= req_b;
                        bus_addr  <= A_AD;
                        bus_wr_en <= 1'b1;
                        bus_wdata <= req_a;
                        state     <= ST_WR_A;
                    end
                end
                ST_WR_A: begin
                    bus_addr  <= B_AD;
                    bus_wr_en <= 1'b1;
                    bus_wdata <= b_q;
                    state     <= ST_WR_B;
                end
                ST_WR_B: begin
                    if (WAIT_CYCLES > 0) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= ST_WAIT;
                    end else begin
                        bus_addr <= RLO_AD;
                        state    <= ST_RD_LO;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        bus_addr <= RLO_AD;
                        state    <= ST_RD_LO;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_RD_LO: begin
                    bus_addr <= RHI_AD;
                    state    <= ST_RD_HI;
                end
                // Read data lags the address by one cycle: low byte arrives during RD_HI.
                ST_RD_HI: begin
                    rsp_r[7:0] <= bus_rdata;
                    state      <= ST_CAP_HI;
                end
                ST_CAP_HI: begin
                    rsp_r[15:8] <= bus_rdata;
                    rsp_valid   <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
